rob_commit_ctrl: RTL and testbench
==================================

// Module: rob_commit_ctrl
// PURPOSE
//  Commit sequencer between ROB head and RegFile/LSB/fetcher. Retires at most one ROB entry per cycle in order,
//  drives the RegFile commit port (rd/Q/V), holds head stores until LSB acks, and on a mispredicted branch
//  issues the one-cycle rollback pulse that clears all RegFile Q tags and redirects fetch.
// PARAMETERS
//  ROB_ID_W   4   ROB tag width; tag 0 = ZERO_ROB (no producer)
//  REG_POS_W  5   architectural register index width; reg 0 = ZERO_REG
//  DATA_W     32  register value width
//  ADDR_W     32  PC width
//  CNT_W      32  retired-instruction counter width (COMMIT_CNT_EN only)
// PORTS
//  clk                    in   1         clock, rising edge
//  rst                    in   1         asynchronous, active-low reset
//  head_valid_from_rob    in   1         ROB non-empty
//  head_ready_from_rob    in   1         head result written back
//  head_id_from_rob       in   ROB_ID_W  head tag
//  head_kind_from_rob     in   2         0 REG, 1 STORE, 2 BRANCH, 3 reserved (treated as REG)
//  head_rd_from_rob       in   REG_POS_W head destination
//  head_V_from_rob        in   DATA_W    head result
//  head_mispred_from_rob  in   1         BRANCH resolved wrong
//  head_pc_from_rob       in   ADDR_W    correct target for mispredict
//  pop_to_rob             out  1         combinational: dequeue head this edge
//  commit_flag_to_rf      out  1         registered commit pulse
//  rollback_flag_to_rf    out  1         registered rollback pulse
//  rd_to_rf / Q_to_rf / V_to_rf  out  REG_POS_W/ROB_ID_W/DATA_W  committed rd, tag, value
//  store_req_to_lsb       out  1         level; head store may write memory
//  store_done_from_lsb    in   1         one-cycle ack, store performed
//  jump_flag_to_if        out  1         registered redirect pulse
//  jump_pc_to_if          out  ADDR_W    redirect target
//  retired_cnt            out  CNT_W     (COMMIT_CNT_EN only)
// BEHAVIOUR
//  Reset (rst low, async): state=COMMIT; all outputs 0; rd/Q/V/jump_pc = ZERO_REG/ZERO_ROB/0/0; counter 0.
//  FSM states: COMMIT, WAIT_ST, FLUSH.
//  COMMIT, head_valid&head_ready:
//   - REG: pop_to_rob=1; next cycle commit_flag=1 with rd/Q/V of head (commit_flag asserted even if rd=0;
//     RegFile ignores rd 0). Stay COMMIT. Back-to-back commits every cycle allowed.
//   - STORE: pop_to_rob=0; store_req_to_lsb=1 from next cycle; -> WAIT_ST. No RegFile write.
//   - BRANCH, !mispred: as REG (link rd committed). Stay COMMIT.
//   - BRANCH, mispred: pop_to_rob=1; next cycle commit_flag (link rd), rollback_flag=1, jump_flag=1,
//     jump_pc=head_pc, all in the same cycle; -> FLUSH.
//  COMMIT, head not valid or not ready: pop=0, all pulses 0 next cycle; stay.
//  WAIT_ST: store_req held high; on store_done: pop_to_rob=1 (combinational, same cycle), store_req drops
//   next cycle, -> COMMIT. Head kind/id must not change while waiting; store_done outside WAIT_ST ignored.
//  FLUSH: exactly one cycle; pop=0, head ignored (ROB clearing); -> COMMIT.
//  Pulses (commit/rollback/jump) last exactly one cycle; rd/Q/V/jump_pc hold last values when pulses low.
//  Latency: head ready -> commit_flag 1 cycle; store ack -> pop 0 cycles.
//  Reset mid-WAIT_ST or mid-FLUSH: abandons operation, no pop, no pulse.
//  Simultaneous rollback+commit: both asserted; RegFile writes V then clears all Q (rollback wins on Q).
// CONFIGURATION
//  COMMIT_CNT_EN defined: retired_cnt increments by 1 each cycle pop_to_rob=1 (wraps at 2^CNT_W), cleared
//   only by reset, not by rollback. Undefined: port and counter absent; no other behaviour change.
// STRUCTURE
//  Shared defines file: ROB_ID_TYPE, REG_POS_TYPE, DATA_TYPE, ADDR_TYPE, ZERO_ROB, ZERO_REG, ZERO_WORD,
//   TRUE/FALSE, head_kind encodings (KIND_REG/KIND_STORE/KIND_BRANCH), FSM state encodings.
//  Single flat module; no sub-module (FSM + output regs only).
// TESTING
//  1 REG head rd=5 id=3 V=0xDEAD ready 3 consecutive cycles (ids 3,4,5) -> pop 3 cycles, commit_flag 3
//    consecutive cycles next, rd/Q/V match each entry.
//  2 STORE head id=6, store_done after 4 cycles -> store_req high 4 cycles, pop only on ack cycle, no
//    commit_flag throughout.
//  3 BRANCH mispred rd=1 V=0x104 pc=0x200 -> next cycle commit_flag, rollback_flag, jump_flag=1,
//    jump_pc=0x200; following cycle all 0, no pop in FLUSH even with ready head.
//  4 head_valid=1 ready=0 for 5 cycles -> no pop, no pulses; ready rises -> commit next cycle.
//  5 rst low asynchronously mid-WAIT_ST -> outputs 0 immediately, state COMMIT after release, no pop.
//  6 COMMIT_CNT_EN: 10 commits incl. one store and one mispredict -> retired_cnt=10; undefined build compiles
//    without the port.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared definitions for the ROB commit sequencer: widths, zero tags, head kinds, FSM encodings.
// Optional retired-instruction counter is enabled with the COMMIT_CNT_EN macro.
package rob_commit_ctrl_pkg;

    localparam int ROB_ID_W  = 4;
    localparam int REG_POS_W = 5;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 32;

    typedef logic [ROB_ID_W-1:0]  rob_id_t;
    typedef logic [REG_POS_W-1:0] reg_pos_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ADDR_W-1:0]    addr_t;

    localparam rob_id_t  ZERO_ROB  = '0;
    localparam reg_pos_t ZERO_REG  = '0;
    localparam data_t    ZERO_WORD = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Head kind encodings; 3 is reserved and retires like a plain register write.
    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;
    localparam logic [1:0] KIND_RSVD   = 2'd3;

    localparam logic [1:0] ST_COMMIT  = 2'd0;
    localparam logic [1:0] ST_WAIT_ST = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Bundle of ROB-head, RegFile commit, LSB store handshake and fetch redirect signals.
// master = commit controller, slave = surrounding ROB/RegFile/LSB/fetch logic.
interface rob_commit_ctrl_if
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_ID_W  = rob_commit_ctrl_pkg::ROB_ID_W,
    parameter int REG_POS_W = rob_commit_ctrl_pkg::REG_POS_W,
    parameter int DATA_W    = rob_commit_ctrl_pkg::DATA_W,
    parameter int ADDR_W    = rob_commit_ctrl_pkg::ADDR_W
) ();

    logic                 head_valid_from_rob;
    logic                 head_ready_from_rob;
    logic [ROB_ID_W-1:0]  head_id_from_rob;
    logic [1:0]           head_kind_from_rob;
    logic [REG_POS_W-1:0] head_rd_from_rob;
    logic [DATA_W-1:0]    head_V_from_rob;
    logic                 head_mispred_from_rob;
    logic [ADDR_W-1:0]    head_pc_from_rob;
    logic                 pop_to_rob;
    logic                 commit_flag_to_rf;
    logic                 rollback_flag_to_rf;
    logic [REG_POS_W-1:0] rd_to_rf;
    logic [ROB_ID_W-1:0]  Q_to_rf;
    logic [DATA_W-1:0]    V_to_rf;
    logic                 store_req_to_lsb;
    logic                 store_done_from_lsb;
    logic                 jump_flag_to_if;
    logic [ADDR_W-1:0]    jump_pc_to_if;

    modport master (
        input  head_valid_from_rob, head_ready_from_rob, head_id_from_rob, head_kind_from_rob,
        input  head_rd_from_rob, head_V_from_rob, head_mispred_from_rob, head_pc_from_rob,
        input  store_done_from_lsb,
        output pop_to_rob, commit_flag_to_rf, rollback_flag_to_rf, rd_to_rf, Q_to_rf, V_to_rf,
        output store_req_to_lsb, jump_flag_to_if, jump_pc_to_if
    );

    modport slave (
        output head_valid_from_rob, head_ready_from_rob, head_id_from_rob, head_kind_from_rob,
        output head_rd_from_rob, head_V_from_rob, head_mispred_from_rob, head_pc_from_rob,
        output store_done_from_lsb,
        input  pop_to_rob, commit_flag_to_rf, rollback_flag_to_rf, rd_to_rf, Q_to_rf, V_to_rf,
        input  store_req_to_lsb, jump_flag_to_if, jump_pc_to_if
    );

endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer at the ROB head: one retirement per cycle, store hold-off, mispredict rollback.
// COMMIT_CNT_EN adds the retired_cnt port counting every ROB pop.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_ID_W  = rob_commit_ctrl_pkg::ROB_ID_W,
    parameter int REG_POS_W = rob_commit_ctrl_pkg::REG_POS_W,
    parameter int DATA_W    = rob_commit_ctrl_pkg::DATA_W,
    parameter int ADDR_W    = rob_commit_ctrl_pkg::ADDR_W
`ifdef COMMIT_CNT_EN
    ,
    parameter int CNT_W     = rob_commit_ctrl_pkg::CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    rob_commit_ctrl_if.master  bus
`ifdef COMMIT_CNT_EN
    ,
    output logic [CNT_W-1:0]   retired_cnt
`endif
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_commit_flag;
    logic                 r_rollback_flag;
    logic                 r_jump_flag;
    logic                 r_store_req;
    logic [REG_POS_W-1:0] r_rd;
    logic [ROB_ID_W-1:0]  r_q;
    logic [DATA_W-1:0]    r_v;
    logic [ADDR_W-1:0]    r_jump_pc;

    logic w_head_go;
    logic w_is_store;
    logic w_is_branch;
    logic w_pop;
    logic w_commit;
    logic w_rollback;
    logic w_store_req_next;

    always_comb begin
        w_head_go        = bus.head_valid_from_rob & bus.head_ready_from_rob;
        w_is_store       = (bus.head_kind_from_rob == KIND_STORE);
        w_is_branch      = (bus.head_kind_from_rob == KIND_BRANCH);
        w_state_next     = r_state;
        w_pop            = 1'b0;
        w_commit         = 1'b0;
        w_rollback       = 1'b0;
        w_store_req_next = r_store_req;
        case (r_state)
            ST_COMMIT: begin
                if (w_head_go) begin
                    if (w_is_store) begin
                        // Stores stay at the head until the LSB confirms the memory write.
                        w_store_req_next = 1'b1;
                        w_state_next     = ST_WAIT_ST;
                    end else begin
                        w_pop    = 1'b1;
                        w_commit = 1'b1;
                        if (w_is_branch && bus.head_mispred_from_rob) begin
                            w_rollback   = 1'b1;
                            w_state_next = ST_FLUSH;
                        end
                    end
                end
            end
            ST_WAIT_ST: begin
                if (bus.store_done_from_lsb) begin
                    w_pop            = 1'b1;
                    w_store_req_next = 1'b0;
                    w_state_next     = ST_COMMIT;
                end
            end
            ST_FLUSH: begin
                // The ROB is clearing this cycle, so whatever sits at the head is stale.
                w_state_next = ST_COMMIT;
            end
            default: begin
                w_state_next = ST_COMMIT;
            end
        endcase
    end

    // Reset must silence the combinational pop too, otherwise a ready head could dequeue mid-reset.
    assign bus.pop_to_rob          = w_pop & rst;
    assign bus.commit_flag_to_rf   = r_commit_flag;
    assign bus.rollback_flag_to_rf = r_rollback_flag;
    assign bus.jump_flag_to_if     = r_jump_flag;
    assign bus.store_req_to_lsb    = r_store_req;
    assign bus.rd_to_rf            = r_rd;
    assign bus.Q_to_rf             = r_q;
    assign bus.V_to_rf             = r_v;
    assign bus.jump_pc_to_if       = r_jump_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_COMMIT;
            r_commit_flag   <= 1'b0;
            r_rollback_flag <= 1'b0;
            r_jump_flag     <= 1'b0;
            r_store_req     <= 1'b0;
            r_rd            <= '0;
            r_q             <= '0;
            r_v             <= '0;
            r_jump_pc       <= '0;
        end else begin
            r_state         <= w_state_next;
            r_commit_flag   <= w_commit;
            r_rollback_flag <= w_rollback;
            r_jump_flag     <= w_rollback;
            r_store_req     <= w_store_req_next;
            if (w_commit) begin
                r_rd <= bus.head_rd_from_rob;
                r_q  <= bus.head_id_from_rob;
                r_v  <= bus.head_V_from_rob;
            end
            if (w_rollback) begin
                r_jump_pc <= bus.head_pc_from_rob;
            end
        end
    end

`ifdef COMMIT_CNT_EN
    logic [CNT_W-1:0] r_retired_cnt;

    // Counts every dequeue, stores included; rollback does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired_cnt <= '0;
        end else if (w_pop) begin
            r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios plus a randomized ROB/LSB environment
// compared against a transaction-level reference model. Counter checks compile only with COMMIT_CNT_EN.
module tb_rob_commit_ctrl;
    import rob_commit_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

`ifdef COMMIT_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
`endif

    rob_commit_ctrl_if bus ();

    rob_commit_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef COMMIT_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        rob_id_t    id;
        reg_pos_t   rd;
        data_t      v;
        logic       mispred;
        addr_t      pc;
    } entry_t;

    task automatic drive_head(input logic valid, input logic ready, input logic [1:0] kind,
                              input rob_id_t id, input reg_pos_t rd, input data_t v,
                              input logic mispred, input addr_t pc);
        bus.head_valid_from_rob   = valid;
        bus.head_ready_from_rob   = ready;
        bus.head_kind_from_rob    = kind;
        bus.head_id_from_rob      = id;
        bus.head_rd_from_rob      = rd;
        bus.head_V_from_rob       = v;
        bus.head_mispred_from_rob = mispred;
        bus.head_pc_from_rob      = pc;
    endtask

    task automatic drive_idle();
        drive_head(1'b0, 1'b0, KIND_REG, '0, '0, '0, 1'b0, '0);
        bus.store_done_from_lsb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({bus.pop_to_rob, bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if,
             bus.store_req_to_lsb} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=00000", {bus.pop_to_rob, bus.commit_flag_to_rf,
                     bus.rollback_flag_to_rf, bus.jump_flag_to_if, bus.store_req_to_lsb});
        end
        n_checks++;
        if (bus.rd_to_rf !== ZERO_REG || bus.Q_to_rf !== ZERO_ROB || bus.V_to_rf !== ZERO_WORD ||
            bus.jump_pc_to_if !== '0) begin
            n_fail++;
            $display("FAIL reset_data got rd=%0d Q=%0d V=%h pc=%h exp all 0",
                     bus.rd_to_rf, bus.Q_to_rf, bus.V_to_rf, bus.jump_pc_to_if);
        end
`ifdef COMMIT_CNT_EN
        n_checks++;
        if (retired_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt got=%0d exp=0", retired_cnt);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_reg_stream();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) drive_head(1'b1, 1'b1, KIND_REG, rob_id_t'(3 + i), 5'd5, 32'hDEAD + i, 1'b0, '0);
            else       drive_idle();
            #1;
            n_checks++;
            if (bus.pop_to_rob !== (i < 3)) begin
                n_fail++;
                $display("FAIL t1_pop cyc=%0d got=%b exp=%b", i, bus.pop_to_rob, (i < 3));
            end
            n_checks++;
            if (bus.commit_flag_to_rf !== (i > 0 && i < 4)) begin
                n_fail++;
                $display("FAIL t1_commit cyc=%0d got=%b exp=%b", i, bus.commit_flag_to_rf, (i > 0 && i < 4));
            end
            if (i > 0) begin
                n_checks++;
                if (bus.rd_to_rf !== 5'd5 || bus.Q_to_rf !== rob_id_t'(2 + (i > 3 ? 3 : i)) ||
                    bus.V_to_rf !== 32'hDEAD + (i > 3 ? 3 : i) - 1) begin
                    n_fail++;
                    $display("FAIL t1_data cyc=%0d got rd=%0d Q=%0d V=%h exp rd=5 Q=%0d V=%h", i,
                             bus.rd_to_rf, bus.Q_to_rf, bus.V_to_rf, 2 + (i > 3 ? 3 : i),
                             32'hDEAD + (i > 3 ? 3 : i) - 1);
                end
                if (bus.commit_flag_to_rf === 1'b1)
                    $display("t1 commit rd=%0d Q=%0d V=%h", bus.rd_to_rf, bus.Q_to_rf, bus.V_to_rf);
            end
        end
    endtask

    task automatic test_store();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 5) drive_head(1'b1, 1'b1, KIND_STORE, 4'd6, 5'd9, 32'h1234, 1'b0, '0);
            else       drive_idle();
            bus.store_done_from_lsb = (i == 0 || i == 4);
            #1;
            n_checks++;
            if (bus.store_req_to_lsb !== (i >= 1 && i <= 4)) begin
                n_fail++;
                $display("FAIL t2_store_req cyc=%0d got=%b exp=%b", i, bus.store_req_to_lsb, (i >= 1 && i <= 4));
            end
            n_checks++;
            if (bus.pop_to_rob !== (i == 4)) begin
                n_fail++;
                $display("FAIL t2_pop cyc=%0d got=%b exp=%b", i, bus.pop_to_rob, (i == 4));
            end
            n_checks++;
            if (bus.commit_flag_to_rf !== 1'b0) begin
                n_fail++;
                $display("FAIL t2_commit cyc=%0d got=%b exp=0", i, bus.commit_flag_to_rf);
            end
        end
        $display("t2 store id=6 retired");
    endtask

    task automatic test_mispredict();
        @(negedge clk);
        drive_head(1'b1, 1'b1, KIND_BRANCH, 4'd7, 5'd1, 32'h104, 1'b1, 32'h200);
        #1;
        n_checks++;
        if (bus.pop_to_rob !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_pop_br got=%b exp=1", bus.pop_to_rob);
        end
        @(negedge clk);
        drive_head(1'b1, 1'b1, KIND_REG, 4'd8, 5'd2, 32'h55, 1'b0, '0);
        #1;
        n_checks++;
        if ({bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if, bus.pop_to_rob} !== 4'b1110) begin
            n_fail++;
            $display("FAIL t3_pulses got=%b exp=1110", {bus.commit_flag_to_rf, bus.rollback_flag_to_rf,
                     bus.jump_flag_to_if, bus.pop_to_rob});
        end
        n_checks++;
        if (bus.jump_pc_to_if !== 32'h200 || bus.rd_to_rf !== 5'd1 || bus.Q_to_rf !== 4'd7 || bus.V_to_rf !== 32'h104) begin
            n_fail++;
            $display("FAIL t3_data got pc=%h rd=%0d Q=%0d V=%h exp pc=200 rd=1 Q=7 V=104",
                     bus.jump_pc_to_if, bus.rd_to_rf, bus.Q_to_rf, bus.V_to_rf);
        end
        $display("t3 rollback jump_pc=%h", bus.jump_pc_to_if);
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if, bus.pop_to_rob} !== 4'b0001) begin
            n_fail++;
            $display("FAIL t3_after_flush got=%b exp=0001", {bus.commit_flag_to_rf, bus.rollback_flag_to_rf,
                     bus.jump_flag_to_if, bus.pop_to_rob});
        end
        @(negedge clk);
        drive_head(1'b1, 1'b1, KIND_BRANCH, 4'd9, 5'd3, 32'h108, 1'b0, 32'h300);
        #1;
        n_checks++;
        if (bus.commit_flag_to_rf !== 1'b1 || bus.Q_to_rf !== 4'd8 || bus.pop_to_rob !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_reg8 got commit=%b Q=%0d pop=%b exp 1/8/1", bus.commit_flag_to_rf,
                     bus.Q_to_rf, bus.pop_to_rob);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if ({bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if} !== 3'b100 ||
            bus.Q_to_rf !== 4'd9 || bus.jump_pc_to_if !== 32'h200) begin
            n_fail++;
            $display("FAIL t3_good_branch got flags=%b Q=%0d pc=%h exp 100/9/200",
                     {bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if},
                     bus.Q_to_rf, bus.jump_pc_to_if);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) drive_head(1'b1, (i == 5), KIND_RSVD, 4'd10, 5'd4, 32'hBEEF, 1'b0, '0);
            else       drive_idle();
            #1;
            n_checks++;
            if (bus.pop_to_rob !== (i == 5) || bus.commit_flag_to_rf !== (i == 6) || bus.store_req_to_lsb !== 1'b0) begin
                n_fail++;
                $display("FAIL t4_stall cyc=%0d got pop=%b commit=%b sreq=%b exp %b/%b/0", i,
                         bus.pop_to_rob, bus.commit_flag_to_rf, bus.store_req_to_lsb, (i == 5), (i == 6));
            end
        end
        n_checks++;
        if (bus.Q_to_rf !== 4'd10 || bus.V_to_rf !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL t4_data got Q=%0d V=%h exp Q=10 V=beef", bus.Q_to_rf, bus.V_to_rf);
        end
        $display("t4 commit Q=%0d after stall", bus.Q_to_rf);
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        drive_head(1'b1, 1'b1, KIND_STORE, 4'd11, 5'd6, 32'h77, 1'b0, '0);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.store_req_to_lsb !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_wait got sreq=%b exp=1", bus.store_req_to_lsb);
        end
        #1;
        rst = 1'b0;
        drive_head(1'b1, 1'b1, KIND_REG, 4'd12, 5'd7, 32'h99, 1'b0, '0);
        #1;
        n_checks++;
        if ({bus.store_req_to_lsb, bus.pop_to_rob, bus.commit_flag_to_rf} !== 3'b000 ||
            bus.Q_to_rf !== ZERO_ROB || bus.jump_pc_to_if !== '0) begin
            n_fail++;
            $display("FAIL t5_async got sreq/pop/commit=%b Q=%0d pc=%h exp 000/0/0",
                     {bus.store_req_to_lsb, bus.pop_to_rob, bus.commit_flag_to_rf}, bus.Q_to_rf, bus.jump_pc_to_if);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.store_req_to_lsb !== 1'b0 || bus.pop_to_rob !== 1'b0) begin
                n_fail++;
                $display("FAIL t5_release cyc=%0d got sreq=%b pop=%b exp 0/0", i, bus.store_req_to_lsb, bus.pop_to_rob);
            end
        end
        @(negedge clk);
        drive_head(1'b1, 1'b1, KIND_REG, 4'd12, 5'd7, 32'h99, 1'b0, '0);
        #1;
        n_checks++;
        if (bus.pop_to_rob !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_commit_state got pop=%b exp=1", bus.pop_to_rob);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (bus.commit_flag_to_rf !== 1'b1 || bus.Q_to_rf !== 4'd12) begin
            n_fail++;
            $display("FAIL t5_commit got commit=%b Q=%0d exp 1/12", bus.commit_flag_to_rf, bus.Q_to_rf);
        end
        $display("t5 reset during store wait recovered, Q=%0d", bus.Q_to_rf);
    endtask

`ifdef COMMIT_CNT_EN
    task automatic test_counter();
        entry_t list [10];
        int     idx;
        int     cyc;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            list[i].kind    = (i == 4) ? KIND_STORE : (i == 6) ? KIND_BRANCH : KIND_REG;
            list[i].id      = rob_id_t'(i + 1);
            list[i].rd      = reg_pos_t'(i);
            list[i].v       = data_t'(i * 3);
            list[i].mispred = (i == 6);
            list[i].pc      = 32'h400;
        end
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 60) begin
            @(negedge clk);
            drive_head(1'b1, 1'b1, list[idx].kind, list[idx].id, list[idx].rd, list[idx].v,
                       list[idx].mispred, list[idx].pc);
            bus.store_done_from_lsb = bus.store_req_to_lsb;
            #1;
            if (bus.pop_to_rob === 1'b1) idx++;
            cyc++;
        end
        n_checks++;
        if (idx != 10) begin
            n_fail++;
            $display("FAIL t6_timeout got retired=%0d exp=10 within 60 cycles", idx);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (retired_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL t6_cnt got=%0d exp=10", retired_cnt);
        end
        $display("t6 retired_cnt=%0d", retired_cnt);
    endtask
`endif

    task automatic test_random();
        entry_t   q [$];
        entry_t   e;
        entry_t   ne;
        rob_id_t  next_id;
        logic     hv, hr, sd, ep, go;
        logic     m_waiting, m_flushing, m_commit, m_rollback;
        reg_pos_t m_rd;
        rob_id_t  m_q;
        data_t    m_v;
        addr_t    m_pc;
        int       m_cnt;
        int       kr;
        do_reset();
        next_id    = 4'd1;
        m_waiting  = 1'b0;
        m_flushing = 1'b0;
        m_commit   = 1'b0;
        m_rollback = 1'b0;
        m_rd       = '0;
        m_q        = '0;
        m_v        = '0;
        m_pc       = '0;
        m_cnt      = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            while (q.size() < 3) begin
                kr          = $urandom_range(0, 19);
                ne.kind     = (kr < 10) ? KIND_REG : (kr < 14) ? KIND_STORE : (kr < 19) ? KIND_BRANCH : KIND_RSVD;
                ne.id       = next_id;
                ne.rd       = reg_pos_t'($urandom);
                ne.v        = data_t'($urandom);
                ne.mispred  = ($urandom_range(0, 2) == 0);
                ne.pc       = addr_t'($urandom);
                next_id     = (next_id == 4'd15) ? 4'd1 : next_id + 4'd1;
                q.push_back(ne);
            end
            e  = q[0];
            hv = ($urandom_range(0, 9) != 0);
            hr = ($urandom_range(0, 9) < 7);
            sd = ($urandom_range(0, 3) == 0);
            drive_head(hv, hr, e.kind, e.id, e.rd, e.v, e.mispred, e.pc);
            bus.store_done_from_lsb = sd;
            #1;
            n_checks++;
            if ({bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if, bus.store_req_to_lsb} !==
                {m_commit, m_rollback, m_rollback, m_waiting}) begin
                n_fail++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c,
                         {bus.commit_flag_to_rf, bus.rollback_flag_to_rf, bus.jump_flag_to_if, bus.store_req_to_lsb},
                         {m_commit, m_rollback, m_rollback, m_waiting});
            end
            n_checks++;
            if (bus.rd_to_rf !== m_rd || bus.Q_to_rf !== m_q || bus.V_to_rf !== m_v || bus.jump_pc_to_if !== m_pc) begin
                n_fail++;
                $display("FAIL rnd_data cyc=%0d got rd=%0d Q=%0d V=%h pc=%h exp rd=%0d Q=%0d V=%h pc=%h", c,
                         bus.rd_to_rf, bus.Q_to_rf, bus.V_to_rf, bus.jump_pc_to_if, m_rd, m_q, m_v, m_pc);
            end
            if (m_commit) $display("rnd commit rd=%0d Q=%0d V=%h rollback=%b", m_rd, m_q, m_v, m_rollback);
            go = !m_waiting && !m_flushing && hv && hr;
            ep = m_waiting ? sd : (go && e.kind != KIND_STORE);
            n_checks++;
            if (bus.pop_to_rob !== ep) begin
                n_fail++;
                $display("FAIL rnd_pop cyc=%0d got=%b exp=%b", c, bus.pop_to_rob, ep);
            end
            m_commit   = go && e.kind != KIND_STORE;
            m_rollback = m_commit && e.kind == KIND_BRANCH && e.mispred;
            m_waiting  = m_waiting ? !sd : (go && e.kind == KIND_STORE);
            m_flushing = m_rollback;
            if (m_commit) begin
                m_rd = e.rd;
                m_q  = e.id;
                m_v  = e.v;
            end
            if (m_rollback) m_pc = e.pc;
            if (ep) begin
                m_cnt++;
                void'(q.pop_front());
            end
            if (m_rollback) q.delete();
        end
`ifdef COMMIT_CNT_EN
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (retired_cnt !== CNT_W'(m_cnt)) begin
            n_fail++;
            $display("FAIL rnd_cnt got=%0d exp=%0d", retired_cnt, m_cnt);
        end
`endif
        $display("test_random done, %0d retirements", m_cnt);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        test_reset();
        test_reg_stream();
        test_store();
        test_mispredict();
        test_stall();
        test_reset_wait();
`ifdef COMMIT_CNT_EN
        test_counter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
